// File: rtl/button_conditioner.sv
// button_conditioner: push-button front end for the soft AVR system.
// Each raw button is synchronised, debounced, and reported as a stable
// level with one-cycle press/release pulses. One chosen channel also
// drives a stretched CPU reset that guarantees the core's minimum
// reset width.
//
// There are no valid/ready handshakes here. Every output is a plain
// registered level or a one-cycle pulse that is valid on every cycle.
module button_conditioner #(
  parameter int NUM_BUTTONS     = 5,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RESET_BUTTON    = 0,
  parameter int RESET_STRETCH   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] buttons_in,
  output logic [NUM_BUTTONS-1:0] buttons_out,
  output logic [NUM_BUTTONS-1:0] pressed,
  output logic [NUM_BUTTONS-1:0] released,
  output logic                   cpu_reset
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = $clog2(RESET_STRETCH + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RCNT_LOAD = RW'(RESET_STRETCH);

  logic [NUM_BUTTONS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_BUTTONS-1:0] sync;
  logic [CW-1:0]          cnt_q  [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] stable_q;
  logic [RW-1:0]          rcnt_q;
  logic [RW-1:0]          rcnt_next;

  // Synchroniser chain: stage 0 captures the asynchronous pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= buttons_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // Debounce: a change is accepted only after DEBOUNCE_CYCLES consecutive
  // cycles of disagreement. Any agreement throws the partial count away.
  // The pulses are registered alongside stable_q so they land on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_q <= '0;
      pressed  <= '0;
      released <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        pressed[i]  <= 1'b0;
        released[i] <= 1'b0;
        if (sync[i] == stable_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          stable_q[i] <= ~stable_q[i];
          cnt_q[i]    <= '0;
          pressed[i]  <= ~stable_q[i];
          released[i] <= stable_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
    end
  end

  assign buttons_out = stable_q;

  // Stretcher next state: reload while any source is high, else count down to 0.
  always_comb begin
    rcnt_next = '0;
    if (reset || stable_q[RESET_BUTTON]) begin
      rcnt_next = RCNT_LOAD;
    end else if (rcnt_q != '0) begin
      rcnt_next = rcnt_q - RW'(1);
    end
  end

  // Stretcher state and registered cpu_reset, which looks ahead to rcnt_next.
  always_ff @(posedge clk) begin
    if (reset) begin
      rcnt_q    <= RCNT_LOAD;
      cpu_reset <= 1'b1;
    end else begin
      rcnt_q    <= rcnt_next;
      cpu_reset <= (rcnt_next != '0);
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: drives three conditioner instances (default,
// wide/fast, single-channel) and checks them every cycle against a
// history-based model. The model works from the acceptance rules and
// the stretch window. Directed sequences pin the model with literal latencies.
module tb_button_conditioner;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic [4:0] btn0  = '0;
  logic [7:0] btn1  = '0;
  logic [0:0] btn2  = '0;

  logic [4:0] bo0, pr0, rel0;
  logic [7:0] bo1, pr1, rel1;
  logic [0:0] bo2, pr2, rel2;
  logic       cpu0, cpu1, cpu2;

  button_conditioner #(.NUM_BUTTONS(5), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16),
                       .RESET_BUTTON(0), .RESET_STRETCH(4)) u0 (
    .clk(clk), .reset(reset), .buttons_in(btn0), .buttons_out(bo0),
    .pressed(pr0), .released(rel0), .cpu_reset(cpu0));

  button_conditioner #(.NUM_BUTTONS(8), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1),
                       .RESET_BUTTON(7), .RESET_STRETCH(2)) u1 (
    .clk(clk), .reset(reset), .buttons_in(btn1), .buttons_out(bo1),
    .pressed(pr1), .released(rel1), .cpu_reset(cpu1));

  button_conditioner #(.NUM_BUTTONS(1), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1),
                       .RESET_BUTTON(0), .RESET_STRETCH(2)) u2 (
    .clk(clk), .reset(reset), .buttons_in(btn2), .buttons_out(bo2),
    .pressed(pr2), .released(rel2), .cpu_reset(cpu2));

  // ---------------- scoreboard counters ----------------
  int tests = 0;
  int fails = 0;

  task automatic check_v(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per instance: raw samples per edge, the value the debouncer sees at
  // each edge, and the last edge on which each channel changed or was reset.
  int p_nb [3] = '{5, 8, 1};
  int p_s  [3] = '{2, 3, 3};
  int p_d  [3] = '{16, 1, 1};
  int p_rs [3] = '{4, 2, 2};
  int p_rb [3] = '{0, 7, 0};

  logic [7:0] samp_h [3][64];
  logic [7:0] seen_h [3][64];
  logic       rst_h  [64];
  logic [7:0] m_stable [3];
  logic [7:0] m_pr     [3];
  logic [7:0] m_rel    [3];
  logic       m_cpu    [3];
  int         m_last_ev  [3][8];
  int         m_last_src [3];
  int         k;

  task automatic model_step(input int inst, input logic [7:0] in_v, input logic rst);
    int s, d;
    logic ok, src, all_diff;
    logic [7:0] seen;
    s = p_s[inst];
    d = p_d[inst];
    samp_h[inst][k % 64] = in_v;
    // The debouncer sees the sample taken s edges ago, unless a reset
    // cleared the chain somewhere along the way.
    ok = (k > s);
    if (ok) begin
      for (int j = 1; j <= s; j++) begin
        if (rst_h[(k - j) % 64]) ok = 1'b0;
      end
    end
    seen = ok ? samp_h[inst][(k - s) % 64] : 8'h00;
    seen_h[inst][k % 64] = seen;
    src = rst | m_stable[inst][p_rb[inst]];
    m_pr[inst]  = '0;
    m_rel[inst] = '0;
    if (rst) begin
      m_stable[inst] = '0;
      for (int i = 0; i < 8; i++) m_last_ev[inst][i] = k;
    end else begin
      for (int i = 0; i < p_nb[inst]; i++) begin
        // Accept when the last d edges, all after the last event, disagreed.
        if (k - m_last_ev[inst][i] >= d) begin
          all_diff = 1'b1;
          for (int j = 0; j < d; j++) begin
            if (seen_h[inst][(k - j) % 64][i] == m_stable[inst][i]) all_diff = 1'b0;
          end
          if (all_diff) begin
            if (m_stable[inst][i]) m_rel[inst][i] = 1'b1;
            else                   m_pr[inst][i]  = 1'b1;
            m_stable[inst][i]  = ~m_stable[inst][i];
            m_last_ev[inst][i] = k;
          end
        end
      end
    end
    if (src) m_last_src[inst] = k;
    m_cpu[inst] = ((k - m_last_src[inst]) < p_rs[inst]);
  endtask

  task automatic compare_all();
    check_v("u0 buttons_out", {3'b0, bo0},  m_stable[0]);
    check_v("u0 pressed",     {3'b0, pr0},  m_pr[0]);
    check_v("u0 released",    {3'b0, rel0}, m_rel[0]);
    check_v("u0 cpu_reset",   {7'b0, cpu0}, {7'b0, m_cpu[0]});
    check_v("u1 buttons_out", bo1,  m_stable[1]);
    check_v("u1 pressed",     pr1,  m_pr[1]);
    check_v("u1 released",    rel1, m_rel[1]);
    check_v("u1 cpu_reset",   {7'b0, cpu1}, {7'b0, m_cpu[1]});
    check_v("u2 buttons_out", {7'b0, bo2},  m_stable[2]);
    check_v("u2 pressed",     {7'b0, pr2},  m_pr[2]);
    check_v("u2 released",    {7'b0, rel2}, m_rel[2]);
    check_v("u2 cpu_reset",   {7'b0, cpu2}, {7'b0, m_cpu[2]});
  endtask

  // Compare process: step the model on each rising edge, check on the falling edge.
  initial begin
    k = 0;
    for (int n = 0; n < 3; n++) begin
      m_stable[n] = '0; m_pr[n] = '0; m_rel[n] = '0; m_cpu[n] = 1'b1;
      m_last_src[n] = -100;
      for (int i = 0; i < 8; i++) m_last_ev[n][i] = 0;
      for (int h = 0; h < 64; h++) begin
        samp_h[n][h] = '0;
        seen_h[n][h] = '0;
      end
    end
    for (int h = 0; h < 64; h++) rst_h[h] = 1'b0;
    forever begin
      @(posedge clk);
      k++;
      model_step(0, {3'b0, btn0}, reset);
      model_step(1, btn1, reset);
      model_step(2, {7'b0, btn2}, reset);
      rst_h[k % 64] = reset;
      @(negedge clk);
      compare_all();
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic cond(input int id);
    case (id)
      0:  return !cpu0;
      1:  return bo0[2];
      2:  return !bo0[2];
      3:  return bo0[1];
      4:  return bo0[0];
      5:  return !bo0[0];
      6:  return bo0[3];
      7:  return !cpu1;
      8:  return bo1[5];
      9:  return bo1[7];
      10: return !bo1[7];
      11: return bo2[0];
      default: return 1'b0;
    endcase
  endfunction

  // Count rising edges until the condition holds (bounded), then compare.
  task automatic wait_edges(input int id, input int exp, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cond(id) && n < 60);
    check_i(name, n, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int changes;
    int rate;

    // Power-up: reset held for edges 1 and 2.
    @(negedge clk);
    check_i("reset buttons_out", int'(bo0), 0);
    check_i("reset pressed", int'(pr0), 0);
    check_i("reset cpu_reset", int'(cpu0), 1);
    @(negedge clk);
    reset = 1'b0;
    wait_edges(0, 4, "powerup cpu_reset fall");
    check_i("powerup buttons_out", int'(bo0), 0);
    tick(5);

    // Clean press on channel 2, held 40 cycles.
    btn0[2] = 1'b1;
    wait_edges(1, 18, "ch2 press latency");
    check_i("ch2 pressed pulse", int'(pr0[2]), 1);
    @(negedge clk);
    check_i("ch2 pulse width", int'(pr0[2]), 0);
    tick(21);
    btn0[2] = 1'b0;
    wait_edges(2, 18, "ch2 release latency");
    check_i("ch2 released pulse", int'(rel0[2]), 1);
    tick(5);

    // Bounce on channel 1: 5-cycle segments for 60 cycles, then steady 1.
    changes = 0;
    for (int seg = 0; seg < 12; seg++) begin
      btn0[1] = (seg % 2 == 0);
      repeat (5) begin
        @(negedge clk);
        if (bo0[1] || pr0[1] || rel0[1]) changes++;
      end
    end
    check_i("bounce quiet", changes, 0);
    btn0[1] = 1'b1;
    wait_edges(3, 18, "bounce press latency");
    check_i("bounce pressed pulse", int'(pr0[1]), 1);
    btn0[1] = 1'b0;
    tick(25);

    // Reset button on channel 0, held 30 cycles.
    btn0[0] = 1'b1;
    wait_edges(4, 18, "rstbtn press latency");
    check_i("rstbtn cpu_reset lags", int'(cpu0), 0);
    @(negedge clk);
    check_i("rstbtn cpu_reset rise", int'(cpu0), 1);
    tick(11);
    btn0[0] = 1'b0;
    wait_edges(5, 18, "rstbtn release latency");
    wait_edges(0, 4, "rstbtn stretch");
    tick(3);

    // Source re-asserts (block reset) during the stretch: no gap in cpu_reset.
    btn0[0] = 1'b1;
    wait_edges(4, 18, "rstbtn2 press latency");
    tick(5);
    btn0[0] = 1'b0;
    wait_edges(5, 18, "rstbtn2 release latency");
    check_i("reload cpu_reset e0", int'(cpu0), 1);
    @(negedge clk);
    check_i("reload cpu_reset e1", int'(cpu0), 1);
    reset = 1'b1;
    @(negedge clk);
    check_i("reload cpu_reset e2", int'(cpu0), 1);
    reset = 1'b0;
    wait_edges(0, 4, "reload stretch fall");
    tick(3);

    // Channels 3 and 4 pressed together, then block reset while held.
    btn0[3] = 1'b1;
    btn0[4] = 1'b1;
    wait_edges(6, 18, "ch3 press latency");
    check_i("ch3/ch4 coincident pulses", int'({pr0[4], pr0[3]}), 3);
    tick(5);
    reset = 1'b1;
    @(negedge clk);
    check_i("midreset buttons_out", int'(bo0[4:3]), 0);
    check_i("midreset no released", int'(rel0[4:3]), 0);
    reset = 1'b0;
    wait_edges(6, 18, "midreset reacquire latency");
    check_i("midreset pressed refire", int'(pr0[3]), 1);
    btn0[3] = 1'b0;
    btn0[4] = 1'b0;
    tick(25);

    // Parameter sweep instances: latency 3+1, stretch 2.
    btn1[5] = 1'b1;
    wait_edges(8, 4, "u1 press latency");
    btn2[0] = 1'b1;
    wait_edges(11, 4, "u2 press latency");
    btn1[7] = 1'b1;
    wait_edges(9, 4, "u1 rstbtn latency");
    btn1[7] = 1'b0;
    wait_edges(10, 4, "u1 rstbtn release");
    wait_edges(7, 2, "u1 stretch");
    btn1 = '0;
    btn2 = '0;
    tick(10);

    // Random phase: per-block toggle rate spans glitches to long holds.
    for (int blk = 0; blk < 10; blk++) begin
      rate = $urandom_range(3, 40);
      repeat (200) begin
        @(negedge clk);
        for (int b = 0; b < 5; b++) if ($urandom_range(0, rate - 1) == 0) btn0[b] = ~btn0[b];
        for (int b = 0; b < 8; b++) if ($urandom_range(0, rate - 1) == 0) btn1[b] = ~btn1[b];
        if ($urandom_range(0, rate - 1) == 0) btn2[0] = ~btn2[0];
        reset = ($urandom_range(0, 249) == 0);
      end
    end
    reset = 1'b0;
    tick(30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

endmodule
